// File: rtl/uart_pkg.sv
// Shared FSM encoding, defaults and width helper for the UART TX scheduling path.
package uart_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } sched_state_e;

  // Index width that never collapses to zero bits for tiny counts.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational winner select: round-robin from a pointer, or fixed priority (index 0 highest).
module uart_rr_arb
  import uart_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  input  logic               prio_mode_i,
  output logic [NUM_REQ-1:0] gnt_oh_c_o,
  output logic [IDX_W-1:0]   gnt_idx_c_o,
  output logic               gnt_vld_c_o
);

  logic [IDX_W-1:0] base_c;
  int unsigned      probe_c;
  logic             found_c;

  // Walk upward from the base with wrap; first set request wins.
  always_comb begin
    gnt_oh_c_o  = '0;
    gnt_idx_c_o = '0;
    found_c     = 1'b0;
    probe_c     = 0;
    base_c      = prio_mode_i ? '0 : ptr_i;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      probe_c = (32'(base_c) + i) % NUM_REQ;
      if (!found_c && req_i[IDX_W'(probe_c)]) begin
        found_c     = 1'b1;
        gnt_idx_c_o = IDX_W'(probe_c);
      end
    end
    gnt_oh_c_o[gnt_idx_c_o] = found_c;
    gnt_vld_c_o             = found_c;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Arbitrates NUM_REQ byte sources onto one uart_tx: one grant per frame, start-timeout
// detection, and an optional forced idle gap between frames.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int unsigned GAP_CYCLES = 0,
  parameter  int unsigned START_TMO  = 4,
  localparam int unsigned IDX_W      = clog2_min1(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable_i,
  input  logic                          prio_mode_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          tx_start_o,
  output logic [DATA_WIDTH-1:0]         tx_data_o,
  input  logic                          tx_busy_i,
  output logic                          active_o,
  output logic [IDX_W-1:0]              grant_id_o,
  output logic                          start_err_o
);

  localparam int unsigned GAP_W = clog2_min1(GAP_CYCLES + 1);
  localparam int unsigned TMO_W = clog2_min1(START_TMO + 1);

  sched_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
  logic                  tx_start_q, tx_start_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [IDX_W-1:0]      grant_id_q, grant_id_d;
  logic                  active_q, active_d;
  logic                  start_err_q, start_err_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;

  logic [NUM_REQ-1:0]    win_oh_c;
  logic [IDX_W-1:0]      win_idx_c;
  logic                  win_vld_c;
  logic [DATA_WIDTH-1:0] win_data_c;
  logic [IDX_W-1:0]      rr_next_c;
  logic                  gap_done_c;
  logic                  tmo_done_c;

  uart_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i       (req_valid_i),
    .ptr_i       (rr_ptr_q),
    .prio_mode_i (prio_mode_i),
    .gnt_oh_c_o  (win_oh_c),
    .gnt_idx_c_o (win_idx_c),
    .gnt_vld_c_o (win_vld_c)
  );

  assign win_data_c = req_data_i[32'(win_idx_c)*DATA_WIDTH +: DATA_WIDTH];
  assign rr_next_c  = (32'(win_idx_c) + 32'd1 >= NUM_REQ) ? '0 : win_idx_c + IDX_W'(1);
  assign gap_done_c = (32'(gap_cnt_q) + 32'd1 >= GAP_CYCLES);
  assign tmo_done_c = (32'(tmo_cnt_q) + 32'd1 >= START_TMO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      grant_id_q  <= '0;
      active_q    <= 1'b0;
      start_err_q <= 1'b0;
      rr_ptr_q    <= '0;
      gap_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      grant_id_q  <= grant_id_d;
      active_q    <= active_d;
      start_err_q <= start_err_d;
      rr_ptr_q    <= rr_ptr_d;
      gap_cnt_q   <= gap_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  // Launch outputs are loaded on the IDLE exit edge so they are registered during LAUNCH.
  always_comb begin
    state_d     = state_q;
    req_ready_d = '0;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    grant_id_d  = grant_id_q;
    start_err_d = start_err_q;
    rr_ptr_d    = rr_ptr_q;
    gap_cnt_d   = '0;
    tmo_cnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (enable_i && win_vld_c && !tx_busy_i) begin
          state_d     = ST_LAUNCH;
          req_ready_d = win_oh_c;
          tx_start_d  = 1'b1;
          tx_data_d   = win_data_c;
          grant_id_d  = win_idx_c;
          if (!prio_mode_i) rr_ptr_d = rr_next_c;
        end
      end
      ST_LAUNCH: state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (tx_busy_i) begin
          state_d = ST_WAIT_DONE;
        end else if (tmo_done_c) begin
          start_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy_i) state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (gap_done_c) state_d = ST_IDLE;
        else            gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    active_d = (state_d != ST_IDLE);
  end

  assign req_ready_o = req_ready_q;
  assign tx_start_o  = tx_start_q;
  assign tx_data_o   = tx_data_q;
  assign grant_id_o  = grant_id_q;
  assign active_o    = active_q;
  assign start_err_o = start_err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: vector table plus multi-cycle corner sequences,
// with a scoreboard of expected grants checked at every tx_start.
module tb_uart_tx_sched;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DW      = 8;
  localparam int unsigned GAP     = 5;
  localparam int unsigned TMO     = 4;
  localparam int unsigned FRAME   = 10;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   enable = 1'b0;
  logic                   prio_mode = 1'b0;
  logic                   force_busy = 1'b0;
  logic                   model_en = 1'b1;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*DW-1:0]  req_data;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   tx_start;
  logic [DW-1:0]          tx_data;
  logic                   tx_busy;
  logic                   active;
  logic [1:0]             grant_id;
  logic                   start_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int unsigned id;
    logic [7:0]  data;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic        prio;
    logic [3:0]  mask;
    logic [7:0]  seed;
    int unsigned id;
  } vec_t;
  vec_t vecs[12];

  int unsigned cnt[NUM_REQ];
  int unsigned sent[NUM_REQ];
  logic [7:0]  seed = 8'h00;
  logic        drop_all = 1'b0;
  logic        b2b_chk = 1'b0;
  logic        fall_vld = 1'b0;
  logic        busy_prev = 1'b0;
  int unsigned cyc = 0;
  int unsigned fall_cyc = 0;
  int unsigned start_cnt = 0;
  int unsigned busy_cnt;
  int unsigned s0;

  uart_tx_sched #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DW),
    .GAP_CYCLES (GAP),
    .START_TMO  (TMO)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_i    (enable),
    .prio_mode_i (prio_mode),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .tx_start_o  (tx_start),
    .tx_data_o   (tx_data),
    .tx_busy_i   (tx_busy),
    .active_o    (active),
    .grant_id_o  (grant_id),
    .start_err_o (start_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mkd(input logic [7:0] s, input int unsigned id, input int unsigned k);
    return s + 8'(16 * id) + 8'(k);
  endfunction

  // Requesters: each holds valid while it still has bytes; payload advances per accepted byte.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]         = (cnt[i] != 0);
      req_data[i*DW +: DW] = mkd(seed, i, sent[i]);
    end
  end

  // uart_tx stand-in: busy for FRAME cycles starting the cycle after tx_start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      busy_cnt <= 0;
    else if (model_en && tx_start)   busy_cnt <= FRAME;
    else if (busy_cnt != 0)          busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = force_busy | (busy_cnt != 0);

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic load(input logic [3:0] mask, input int unsigned nb, input logic [7:0] s);
    seed     = s;
    fall_vld = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sent[i] = 0;
      cnt[i]  = mask[i] ? nb : 0;
    end
  endtask

  task automatic push(input int unsigned id, input int unsigned k);
    exp_t e;
    e.id   = id;
    e.data = mkd(seed, id, k);
    exp_q.push_back(e);
  endtask

  task automatic wait_start(input int unsigned limit, input string name);
    for (int unsigned i = 0; i < limit; i++) begin
      @(negedge clk);
      if (tx_start) return;
    end
    checks++;
    failures++;
    $display("FAIL %s no tx_start within %0d cycles", name, limit);
  endtask

  task automatic wait_idle(input int unsigned limit, input string name);
    for (int unsigned i = 0; i < limit; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !active) return;
    end
    checks++;
    failures++;
    $display("FAIL %s not idle within %0d cycles, pending=%0d", name, limit, exp_q.size());
    exp_q.delete();
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (busy_prev && !tx_busy) begin
      fall_cyc = cyc;
      fall_vld = 1'b1;
    end
    busy_prev = tx_busy;
    if (rst_n && req_ready != 0 && !tx_start) begin
      checks++;
      failures++;
      $display("FAIL ready_outside_launch actual=%b expected=0000", req_ready);
    end
    if (rst_n && tx_start) begin
      start_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_start grant_id=%0d data=%h expected no start", grant_id, tx_data);
      end else begin
        e = exp_q.pop_front();
        chk("grant_id", 32'(grant_id), e.id);
        chk("tx_data", 32'(tx_data), 32'(e.data));
        chk("req_ready", 32'(req_ready), 32'(1) << e.id);
        if (b2b_chk && fall_vld) chk("frame_spacing", cyc - fall_cyc, GAP + 2);
      end
      fall_vld = 1'b0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst_n && req_ready[i] && cnt[i] != 0) begin
        cnt[i]  = cnt[i] - 1;
        sent[i] = sent[i] + 1;
      end
    end
    if (rst_n && req_ready != 0 && drop_all) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // {prio_mode, valid mask, payload seed, expected winner}; rr pointer starts at 0
    vecs[0]  = '{1'b0, 4'b0001, 8'hA5, 0};
    vecs[1]  = '{1'b0, 4'b0001, 8'h11, 0};
    vecs[2]  = '{1'b0, 4'b1001, 8'h22, 3};
    vecs[3]  = '{1'b0, 4'b1001, 8'h33, 0};
    vecs[4]  = '{1'b1, 4'b1010, 8'h44, 1};
    vecs[5]  = '{1'b0, 4'b0110, 8'h55, 1};
    vecs[6]  = '{1'b1, 4'b1100, 8'h66, 2};
    vecs[7]  = '{1'b0, 4'b0101, 8'h77, 2};
    vecs[8]  = '{1'b0, 4'b1111, 8'h88, 3};
    vecs[9]  = '{1'b1, 4'b1000, 8'h99, 3};
    vecs[10] = '{1'b0, 4'b1101, 8'hC0, 0};
    vecs[11] = '{1'b0, 4'b0111, 8'hD0, 1};
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt[i]  = 0;
      sent[i] = 0;
    end

    #1;
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_start_err", 32'(start_err), 0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
    @(negedge clk);

    drop_all = 1'b1;
    for (int v = 0; v < 12; v++) begin
      prio_mode = vecs[v].prio;
      load(vecs[v].mask, 1, vecs[v].seed);
      push(vecs[v].id, 0);
      @(negedge clk);
      chk("start_latency", 32'(tx_start), 1);
      wait_idle(60, "vector");
    end
    drop_all = 1'b0;

    // Reset mid-frame: everything back to reset values immediately.
    prio_mode = 1'b1;
    load(4'b0100, 1, 8'h7E);
    push(2, 0);
    wait_start(20, "rst_mid_start");
    repeat (3) @(negedge clk);
    chk("pre_rst_active", 32'(active), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_start", 32'(tx_start), 0);
    chk("midrst_req_ready", 32'(req_ready), 0);
    chk("midrst_tx_data", 32'(tx_data), 0);
    chk("midrst_active", 32'(active), 0);
    chk("midrst_grant_id", 32'(grant_id), 0);
    chk("midrst_start_err", 32'(start_err), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Round-robin fairness from pointer 0, then fixed priority, then plain gap spacing.
    b2b_chk   = 1'b1;
    prio_mode = 1'b0;
    load(4'b1111, 2, 8'h30);
    for (int k = 0; k < 2; k++)
      for (int id = 0; id < 4; id++) push(id, k);
    wait_idle(400, "rr_fair");

    prio_mode = 1'b1;
    load(4'b1010, 3, 8'h40);
    for (int k = 0; k < 3; k++) push(1, k);
    for (int k = 0; k < 3; k++) push(3, k);
    wait_idle(400, "fixed_prio");

    load(4'b0001, 2, 8'hB0);
    push(0, 0);
    push(0, 1);
    wait_idle(200, "gap");
    b2b_chk = 1'b0;

    // enable dropped mid-frame: frame finishes, second byte waits.
    load(4'b0001, 2, 8'h50);
    push(0, 0);
    wait_start(20, "en_first");
    @(negedge clk);
    s0     = start_cnt;
    enable = 1'b0;
    repeat (60) @(negedge clk);
    chk("en_off_starts", start_cnt - s0, 0);
    chk("en_off_active", 32'(active), 0);
    push(0, 1);
    enable = 1'b1;
    wait_idle(100, "en_resume");

    // Foreign busy while idle blocks grants until it drops.
    force_busy = 1'b1;
    load(4'b0100, 1, 8'h60);
    s0 = start_cnt;
    repeat (20) @(negedge clk);
    chk("busy_idle_starts", start_cnt - s0, 0);
    chk("busy_idle_active", 32'(active), 0);
    push(2, 0);
    force_busy = 1'b0;
    wait_idle(100, "busy_release");

    // Start timeout: uart_tx never answers.
    model_en = 1'b0;
    load(4'b0001, 1, 8'h90);
    push(0, 0);
    wait_start(20, "tmo_start");
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n == 4) begin
        chk("tmo_err_early", 32'(start_err), 0);
        chk("tmo_active_early", 32'(active), 1);
      end
      if (n == 5) begin
        chk("tmo_err_set", 32'(start_err), 1);
        chk("tmo_back_idle", 32'(active), 0);
      end
    end
    model_en = 1'b1;
    load(4'b0001, 1, 8'hA0);
    push(0, 0);
    wait_idle(100, "after_tmo");
    chk("tmo_err_sticky", 32'(start_err), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
